// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit.
// Pure declarations, no logic, so there is no latency.
// No flow control lives here.
package ex_muldiv_pkg;

    // Architectural HI/LO and operand width.
    localparam int XLEN = 32;

    // Funct codes of the R-type instructions this unit consumes.
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // Sequencer states; kept as plain constants so older tools that
    // compare against raw encodings keep working.
    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_MUL  = 2'd1;
    localparam md_state_t ST_DIV  = 2'd2;
    localparam md_state_t ST_FIX  = 2'd3;

endpackage

// File: rtl/ex_muldiv_abs_neg.sv
// Conditional two's-complement negate.
// Purely combinational, zero cycles.
// No flow control.
module muldiv_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    // Negating the most negative value wraps to itself, which is exactly
    // the unsigned magnitude the iterative datapath expects.
    always_comb begin
        y = neg ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, plus MTHI/MTLO writes.
// Accept edge, 32 iteration edges, then one sign-fix edge that writes HI/LO.
// busy stalls the front end; new ops while busy are ignored; flush aborts.
module ex_muldiv_unit #(
    parameter int XLEN  = ex_muldiv_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid_i,
    input  logic [5:0]      funct_i,
    input  logic [XLEN-1:0] rs_val_i,
    input  logic [XLEN-1:0] rt_val_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            done_o
);

    import ex_muldiv_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    md_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    // Multiplicand during MUL, divisor during DIV.
    logic [XLEN-1:0]  opnd_q;
    // Upper half: product accumulator / partial remainder.
    logic [XLEN-1:0]  work_hi_q;
    // Lower half: remaining multiplier bits / dividend-then-quotient.
    logic [XLEN-1:0]  work_lo_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic             is_div_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic             done_q;

    logic             is_signed_op;
    logic             neg_rs;
    logic             neg_rt;
    logic [XLEN-1:0]  rs_mag;
    logic [XLEN-1:0]  rt_mag;
    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]  quot_fix;
    logic [XLEN-1:0]  rem_fix;

    // Operand magnitude selection for signed ops.
    always_comb begin
        is_signed_op = (funct_i == FN_MULT) || (funct_i == FN_DIV);
        neg_rs       = is_signed_op && rs_val_i[XLEN-1];
        neg_rt       = is_signed_op && rt_val_i[XLEN-1];
    end

    muldiv_abs_neg #(.W(XLEN)) u_rs_mag (
        .a   (rs_val_i),
        .neg (neg_rs),
        .y   (rs_mag)
    );

    muldiv_abs_neg #(.W(XLEN)) u_rt_mag (
        .a   (rt_val_i),
        .neg (neg_rt),
        .y   (rt_mag)
    );

    // One shift-add step and one restoring-divide step, both from current state.
    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opnd_q : {XLEN{1'b0}})};
        rem_shift = {work_hi_q, work_lo_q[XLEN-1]};
        div_diff  = rem_shift - {1'b0, opnd_q};
    end

    // Sign fix applied in FIX: full product, quotient, remainder.
    muldiv_abs_neg #(.W(2*XLEN)) u_prod_fix (
        .a   ({work_hi_q, work_lo_q}),
        .neg (sign_q_q),
        .y   (prod_fix)
    );

    muldiv_abs_neg #(.W(XLEN)) u_quot_fix (
        .a   (work_lo_q),
        .neg (sign_q_q),
        .y   (quot_fix)
    );

    muldiv_abs_neg #(.W(XLEN)) u_rem_fix (
        .a   (work_hi_q),
        .neg (sign_r_q),
        .y   (rem_fix)
    );

    // Sequencer, iteration datapath and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                // Squash wins over both accept and any in-flight step.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (op_valid_i) begin
                            case (funct_i)
                                FN_MULT, FN_MULTU: begin
                                    state_q   <= ST_MUL;
                                    cnt_q     <= '0;
                                    opnd_q    <= rs_mag;
                                    work_hi_q <= '0;
                                    work_lo_q <= rt_mag;
                                    sign_q_q  <= neg_rs ^ neg_rt;
                                    sign_r_q  <= neg_rs;
                                    is_div_q  <= 1'b0;
                                end
                                FN_DIV, FN_DIVU: begin
                                    state_q   <= ST_DIV;
                                    cnt_q     <= '0;
                                    opnd_q    <= rt_mag;
                                    work_hi_q <= '0;
                                    work_lo_q <= rs_mag;
                                    sign_q_q  <= neg_rs ^ neg_rt;
                                    sign_r_q  <= neg_rs;
                                    is_div_q  <= 1'b1;
                                end
                                FN_MTHI: hi_q <= rs_val_i;
                                FN_MTLO: lo_q <= rs_val_i;
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        work_hi_q <= mul_sum[XLEN:1];
                        work_lo_q <= {mul_sum[0], work_lo_q[XLEN-1:1]};
                        cnt_q     <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) state_q <= ST_FIX;
                    end
                    ST_DIV: begin
                        if (!div_diff[XLEN]) begin
                            work_hi_q <= div_diff[XLEN-1:0];
                            work_lo_q <= {work_lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            work_hi_q <= rem_shift[XLEN-1:0];
                            work_lo_q <= {work_lo_q[XLEN-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) state_q <= ST_FIX;
                    end
                    ST_FIX: begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[2*XLEN-1:XLEN];
                            lo_q <= prod_fix[XLEN-1:0];
                        end
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Outputs are straight from state; busy is decoded, not registered.
    always_comb begin
        hi_o   = hi_q;
        lo_o   = lo_q;
        busy_o = (state_q != ST_IDLE);
        done_o = done_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit with an expected-result queue.
// Results are compared on the done pulse; latency measured via busy.
// Stimulus respects the hazard contract; violations are flagged.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid_i (op_valid),
        .funct_i    (funct),
        .rs_val_i   (rs_val),
        .rt_val_i   (rt_val),
        .flush_i    (flush),
        .hi_o       (hi),
        .lo_o       (lo),
        .busy_o     (busy),
        .done_o     (done)
    );

    // Hazard contract: no new op while the unit is busy.
    always @(posedge clk) begin
        if (reset === 1'b1)
            assert (!(busy === 1'b1 && op_valid === 1'b1))
                else $error("hazard contract broken: op_valid while busy");
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    // Drive one op for the accept edge, deassert just after it.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        funct    = f;
        rs_val   = a;
        rt_val   = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Count busy cycles until done (bounded); report HI/LO at last busy sample.
    task automatic wait_done(output int cyc, output bit got, output logic [63:0] last_busy_hilo);
        cyc = 0;
        got = 1'b0;
        last_busy_hilo = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                cyc++;
                last_busy_hilo = {hi, lo};
            end
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Full op: push expectation, run, and check latency, hold, result, pulse width.
    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_hilo);
        int cyc;
        bit got;
        logic [63:0] held;
        logic [63:0] want;
        sb_q.push_back(exp_hilo);
        issue(f, a, b);
        wait_done(cyc, got, held);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout got=%0b want=1", name, got);
        end
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d want=33", name, cyc);
        end
        checks++;
        if (held !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL %s hilo_hold got=%h want=%h", name, held, {m_hi, m_lo});
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty got=0 want=1", name);
        end else begin
            want = sb_q.pop_front();
            if ({hi, lo} !== want) begin
                errors++;
                $display("FAIL %s result got=%h want=%h", name, {hi, lo}, want);
            end
            m_hi = want[63:32];
            m_lo = want[31:0];
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse got=%b%b want=00", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        op_valid = 1'b0;
        funct    = 6'h0;
        rs_val   = '0;
        rt_val   = '0;
        flush    = 1'b0;
        m_hi     = '0;
        m_lo     = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state got=%h %h %b %b want=0 0 0 0", hi, lo, busy, done);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_mult();
        run_op("mult_neg3x5", 6'h18, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    endtask

    task automatic test_multu();
        run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    endtask

    task automatic test_back_to_back();
        run_op("div_neg7by2",  6'h1A, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_by0",     6'h1B, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF);
        run_op("div_overflow", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("div_neg7by0",  6'h1A, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_0000_0001);
    endtask

    task automatic test_mt();
        int d0;
        d0 = done_seen;
        @(negedge clk);
        op_valid = 1'b1;
        funct    = 6'h11;
        rs_val   = 32'h1234_5678;
        @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== m_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi got=%h %h %b want=12345678 %h 0", hi, lo, busy, m_lo);
        end
        funct  = 6'h13;
        rs_val = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo got=%h %h %b want=12345678 9abcdef0 0", hi, lo, busy);
        end
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;
        // Unknown funct must be ignored.
        funct  = 6'h20;
        rs_val = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        checks++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL unknown_funct got=%h %h %b want=%h %h 0", hi, lo, busy, m_hi, m_lo);
        end
        // Flush beats an MTHI accept.
        funct = 6'h11;
        flush = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (hi !== m_hi) begin
            errors++;
            $display("FAIL flush_mthi got=%h want=%h", hi, m_hi);
        end
        @(negedge clk);
        checks++;
        if (done_seen !== d0) begin
            errors++;
            $display("FAIL mt_no_done got=%0d want=%0d", done_seen - d0, 0);
        end
    endtask

    task automatic test_flush();
        int d0;
        @(negedge clk);
        op_valid = 1'b1;
        funct    = 6'h11;
        rs_val   = 32'h0000_AAAA;
        @(posedge clk);
        #1;
        funct  = 6'h13;
        rs_val = 32'h0000_5555;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        m_hi = 32'h0000_AAAA;
        m_lo = 32'h0000_5555;
        d0 = done_seen;
        issue(6'h1A, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_before got=%b want=1", busy);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_after got=%b want=0", busy);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
            errors++;
            $display("FAIL flush_hilo got=%h %h want=0000aaaa 00005555", hi, lo);
        end
        checks++;
        if (done_seen !== d0) begin
            errors++;
            $display("FAIL flush_no_done got=%0d want=0", done_seen - d0);
        end
    endtask

    task automatic test_reset_mid();
        issue(6'h18, 32'd123456, 32'd789);
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h %h %b %b want=0 0 0 0", hi, lo, busy, done);
        end
        m_hi = '0;
        m_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run_op("multu_after_reset", 6'h19, 32'd3, 32'd4, 64'h0000_0000_0000_000C);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_back_to_back();
        test_mt();
        test_flush();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
